// File: rtl/pulse_meas_pkg.sv
// Shared types and constants for the pulse measurement block.
// FSM state encoding, logic-analyzer bit map and counter width default.
package pulse_meas_pkg;

    localparam int unsigned CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RISE = 3'd1,
        ST_HIGH      = 3'd2,
        ST_LOW       = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    // Control bits on la_data_in (qualified by la_oenb at the wrapper)
    localparam int unsigned LA_ARM_BIT     = 0;
    localparam int unsigned LA_ABORT_BIT   = 1;
    localparam int unsigned LA_CNT_EN_BIT  = 2;
    localparam int unsigned LA_CNT_CLR_BIT = 3;

    // Readback field offsets on la_data_out
    localparam int unsigned LA_HIGH_W_OFS   = 0;
    localparam int unsigned LA_PERIOD_OFS   = 32;
    localparam int unsigned LA_EDGE_CNT_OFS = 64;
    localparam int unsigned LA_STATUS_OFS   = 96;

endpackage

// File: rtl/pulse_meas_sync.sv
// Input conditioning: synchronizer, optional glitch filter, rise detector.
// Glitch filter is built only when PULSE_MEAS_GLITCH_FILTER_EN is defined.
module pulse_meas_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pulse_i,
    output logic lvl_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ps;
    logic                   lvl;
    logic                   lvl_dly_q, lvl_dly_d;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], pulse_i};
        lvl_dly_d = lvl;
    end

    assign ps = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            lvl_dly_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            lvl_dly_q <= lvl_dly_d;
        end
    end

`ifdef PULSE_MEAS_GLITCH_FILTER_EN
    localparam int unsigned FC_W = $clog2(FILT_LEN + 1);

    logic            filt_q, filt_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;

    // Same delay on both edges keeps measured widths exact
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (ps != filt_q) begin
            if (fcnt_q == FC_W'(FILT_LEN - 1)) filt_d = ps;
            else                               fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign lvl = filt_q;
`else
    logic unused_filt;
    assign unused_filt = ^FILT_LEN;
    assign lvl         = ps;
`endif

    assign lvl_o  = lvl;
    assign rise_o = lvl & ~lvl_dly_q;

endmodule

// File: rtl/pulse_meas.sv
// Single-shot pulse high-width / period measurement plus free-running edge counter.
// Optional PULSE_MEAS_GLITCH_FILTER_EN adds a FILT_LEN-cycle input filter.
module pulse_meas
    import pulse_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             pulse_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             cnt_en_i,
    input  logic             cnt_clr_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic             ovf_o,
    output logic [CNT_W-1:0] high_w_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] edge_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic lvl, rise;

    pulse_meas_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sync (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_ni),
        .pulse_i (pulse_i),
        .lvl_o   (lvl),
        .rise_o  (rise)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hc_q, hc_d, pc_q, pc_d;
    logic [CNT_W-1:0] high_w_q, high_w_d, period_q, period_d, edge_q, edge_d;
    logic             valid_q, valid_d, ovf_q, ovf_d;
    logic [CNT_W-1:0] hc_inc, pc_inc;

    assign hc_inc = hc_q + 1'b1;
    assign pc_inc = pc_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        hc_d     = hc_q;
        pc_d     = pc_q;
        high_w_d = high_w_q;
        period_d = period_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        // abort blocks arm in the same cycle, even from IDLE
        if (abort_i) begin
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_i) begin
                        state_d = ST_WAIT_RISE;
                        valid_d = 1'b0;
                        ovf_d   = 1'b0;
                        hc_d    = '0;
                        pc_d    = '0;
                    end
                end
                ST_WAIT_RISE: begin
                    if (rise) begin
                        state_d = ST_HIGH;
                        hc_d    = CNT_W'(1);
                        pc_d    = CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (lvl) begin
                        hc_d = hc_inc;
                        pc_d = pc_inc;
                        if (hc_inc == CNT_MAX || pc_inc == CNT_MAX) begin
                            high_w_d = hc_inc;
                            period_d = pc_inc;
                            ovf_d    = 1'b1;
                            valid_d  = 1'b1;
                            state_d  = ST_DONE;
                        end
                    end else begin
                        high_w_d = hc_q;
                        pc_d     = pc_inc;
                        state_d  = ST_LOW;
                        if (pc_inc == CNT_MAX) begin
                            period_d = pc_inc;
                            ovf_d    = 1'b1;
                            valid_d  = 1'b1;
                            state_d  = ST_DONE;
                        end
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        period_d = pc_q;
                        valid_d  = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        pc_d = pc_inc;
                        if (pc_inc == CNT_MAX) begin
                            period_d = pc_inc;
                            ovf_d    = 1'b1;
                            valid_d  = 1'b1;
                            state_d  = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        edge_d = edge_q;
        if (cnt_clr_i)                                edge_d = '0;
        else if (rise && cnt_en_i && edge_q != CNT_MAX) edge_d = edge_q + 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q  <= ST_IDLE;
            hc_q     <= '0;
            pc_q     <= '0;
            high_w_q <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            edge_q   <= '0;
        end else begin
            state_q  <= state_d;
            hc_q     <= hc_d;
            pc_q     <= pc_d;
            high_w_q <= high_w_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            edge_q   <= edge_d;
        end
    end

    assign busy_o     = (state_q == ST_WAIT_RISE) || (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign valid_o    = valid_q;
    assign ovf_o      = ovf_q;
    assign high_w_o   = high_w_q;
    assign period_o   = period_q;
    assign edge_cnt_o = edge_q;

endmodule

// File: tb/tb_pulse_meas.sv
// Randomized bench for pulse_meas: a 32-bit and a 4-bit instance share stimulus
// and are checked against a width/period/edge model derived from pulse lengths.
module tb_pulse_meas;

`ifdef PULSE_MEAS_GLITCH_FILTER_EN
    localparam int FLT = 4;
`else
    localparam int FLT = 0;
`endif
    localparam int LAT   = 3 + FLT;           // pulse_i change to sampled rise
    localparam int MINW  = (FLT > 0) ? FLT : 1;
    localparam int GAP   = LAT + 3;
    localparam int CLOSE = MINW + 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic pulse = 1'b0, arm = 1'b0, abort = 1'b0, cnt_en = 1'b0, cnt_clr = 1'b0;

    logic        busy32, valid32, ovf32, busy4, valid4, ovf4;
    logic [31:0] hw32, per32, edge32;
    logic [3:0]  hw4, per4, edge4;

    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    pulse_meas #(.CNT_W(32)) u_dut32 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .pulse_i(pulse), .arm_i(arm), .abort_i(abort),
        .cnt_en_i(cnt_en), .cnt_clr_i(cnt_clr), .busy_o(busy32), .valid_o(valid32),
        .ovf_o(ovf32), .high_w_o(hw32), .period_o(per32), .edge_cnt_o(edge32));

    pulse_meas #(.CNT_W(4)) u_dut4 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .pulse_i(pulse), .arm_i(arm), .abort_i(abort),
        .cnt_en_i(cnt_en), .cnt_clr_i(cnt_clr), .busy_o(busy4), .valid_o(valid4),
        .ovf_o(ovf4), .high_w_o(hw4), .period_o(per4), .edge_cnt_o(edge4));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected result for one pulse of h high / l low cycles in a w-bit counter
    function automatic void exp_meas(input int w, input int h, input int l,
                                     output longint eh, output longint ep, output bit eo);
        longint mx;
        mx = (longint'(1) << w) - 1;
        if (h >= mx)          begin eh = mx; ep = mx;    eo = 1'b1; end
        else if (h + l >= mx) begin eh = h;  ep = mx;    eo = 1'b1; end
        else                  begin eh = h;  ep = h + l; eo = 1'b0; end
    endfunction

    task automatic wait_valid();
        int n = 0;
        while (!valid32 && n < 300) begin
            tick();
            n++;
        end
        chk("valid32", valid32, 1);
    endtask

    task automatic meas(input int h, input int l, input bit mid_arm);
        longint eh, ep;
        bit     eo;
        arm = 1'b1; tick(); arm = 1'b0;
        chk("arm_valid_clr", valid32, 0);
        chk("arm_busy", busy32, 1);
        repeat ($urandom_range(0, 4)) tick();
        pulse = 1'b1;
        for (int i = 0; i < h; i++) begin
            if (mid_arm && i == 1) arm = 1'b1;
            tick();
            arm = 1'b0;
        end
        pulse = 1'b0; repeat (l) tick();
        pulse = 1'b1; repeat (CLOSE) tick();
        pulse = 1'b0;
        wait_valid();
        exp_meas(32, h, l, eh, ep, eo);
        chk("high_w32", hw32, eh);
        chk("period32", per32, ep);
        chk("ovf32", ovf32, eo);
        chk("busy32_done", busy32, 0);
        exp_meas(4, h, l, eh, ep, eo);
        chk("valid4", valid4, 1);
        chk("high_w4", hw4, eh);
        chk("period4", per4, ep);
        chk("ovf4", ovf4, eo);
        chk("busy4_done", busy4, 0);
        repeat (GAP) tick();
    endtask

    initial begin
        int bad, exp_e, en;
        repeat (3) tick();
        chk("rst_busy", busy32, 0);
        chk("rst_valid", valid32, 0);
        chk("rst_ovf", ovf32, 0);
        chk("rst_high_w", hw32, 0);
        chk("rst_period", per32, 0);
        chk("rst_edge", edge32, 0);
        chk("rst_busy4", busy4, 0);
        rst_n = 1'b1;
        repeat (GAP) tick();

        meas(5, 7, 1'b0);

        // reset in the middle of a measurement drops everything
        arm = 1'b1; tick(); arm = 1'b0;
        pulse = 1'b1; repeat (LAT + 3) tick();
        rst_n = 1'b0; tick();
        chk("rstmid_busy", busy32, 0);
        chk("rstmid_valid", valid32, 0);
        chk("rstmid_high_w", hw32, 0);
        rst_n = 1'b1; pulse = 1'b0;
        repeat (GAP) tick();

        meas(20, 5, 1'b0);

        // no input: busy held until abort
        arm = 1'b1; tick(); arm = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy32 || !busy4) bad++;
            tick();
        end
        chk("nopulse_busy_drops", bad, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", busy32, 0);
        chk("abort_valid", valid32, 0);

        // arm together with abort while waiting: abort wins
        arm = 1'b1; tick(); arm = 1'b0;
        chk("wait_busy", busy32, 1);
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        chk("armabort_busy", busy32, 0);
        chk("armabort_valid", valid32, 0);
        arm = 1'b1; tick(); arm = 1'b0;
        chk("rearm_busy", busy32, 1);
        abort = 1'b1; tick(); abort = 1'b0;

        for (int k = 0; k < 14; k++)
            meas($urandom_range(MINW, 20), $urandom_range(MINW, 20), 1'($urandom_range(0, 1)));

        // edge counter: clear coincides with the 6th rise
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        cnt_en = 1'b1;
        for (int p = 1; p <= 10; p++) begin
            pulse = 1'b1;
            repeat (LAT - 1) tick();
            if (p == 6) cnt_clr = 1'b1;
            tick();
            cnt_clr = 1'b0;
            tick();
            pulse = 1'b0;
            repeat (GAP) tick();
        end
        chk("edge_clr32", edge32, 4);
        chk("edge_clr4", edge4, 4);

        // random enable per pulse; 4-bit instance saturates
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        exp_e = 0;
        for (int p = 0; p < 40; p++) begin
            en = $urandom_range(0, 3) != 0;
            cnt_en = 1'(en);
            pulse = 1'b1; repeat ($urandom_range(MINW, MINW + 2)) tick();
            pulse = 1'b0; repeat (GAP) tick();
            exp_e += en;
        end
        cnt_en = 1'b0;
        chk("edge_rand32", edge32, exp_e);
        chk("edge_rand4", edge4, (exp_e > 15) ? 15 : exp_e);

`ifdef PULSE_MEAS_GLITCH_FILTER_EN
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        cnt_en = 1'b1;
        arm = 1'b1; tick(); arm = 1'b0;
        pulse = 1'b1; repeat (2) tick();
        pulse = 1'b0; repeat (GAP) tick();
        pulse = 1'b1; repeat (10) tick();
        pulse = 1'b0; repeat (10) tick();
        pulse = 1'b1; repeat (6) tick();
        pulse = 1'b0;
        wait_valid();
        chk("glitch_high_w", hw32, 10);
        chk("glitch_period", per32, 20);
        repeat (GAP) tick();
        chk("glitch_edges", edge32, 2);
        cnt_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_meas.md
Name: pulse_meas

Overview:
- Measurement end of the on-chip pulse generator. Samples one pulse train (from the generator output or a GPIO pad), then measures high width, period and rising-edge count.
- Results are returned to the management SoC through the logic-analyzer readback path (la_data_out).
- Instantiated inside the user project beside the pulse generator. Control arrives on la_data_in bits qualified by la_oenb.

Parameters:
- CNT_W, 32, width of the high-width, period and edge counters
- SYNC_STAGES, 2, flops in the input synchronizer (minimum 2)
- FILT_LEN, 4, stable cycles required by the glitch filter (used only with the optional feature)

Ports:
- wb_clk_i  in  1  single clock for the block
- wb_rst_ni  in  1  synchronous, active-low reset
- pulse_i  in  1  pulse under test; asynchronous to wb_clk_i
- arm_i  in  1  one-cycle request to start a single-shot measurement
- abort_i  in  1  one-cycle request to cancel a measurement in progress
- cnt_en_i  in  1  enables the free-running rising-edge counter
- cnt_clr_i  in  1  clears the edge counter
- busy_o  out  1  high while the FSM is not in IDLE or DONE
- valid_o  out  1  results are valid; held until the next arm
- ovf_o  out  1  a counter saturated during the last measurement
- high_w_o  out  CNT_W  high-time, in clock cycles
- period_o  out  CNT_W  rising edge to next rising edge, in clock cycles
- edge_cnt_o  out  CNT_W  rising edges seen while cnt_en_i is high

Behaviour:
- Reset (wb_rst_ni=0 at a clock edge):
  - Every output is 0; the FSM goes to IDLE; the synchronizer flops are cleared.
  - A reset in the middle of a measurement discards it; no partial result is latched.
- Input path:
  - pulse_i passes through SYNC_STAGES flops, giving ps.
  - A one-flop delay of ps, ps_d, gives rise = ps & ~ps_d.
  - Both edges are delayed equally, so measured widths are exact.
- FSM states: IDLE, WAIT_RISE, HIGH, LOW, DONE.
  - IDLE/DONE + arm_i: go to WAIT_RISE. valid_o=0, ovf_o=0, internal counters cleared.
  - WAIT_RISE + rise: go to HIGH. The high counter hc is set to 1 and the period counter pc to 1.
  - HIGH: hc and pc increment each cycle that ps=1. When ps=0, latch high_w_o=hc and go to LOW (pc increments that cycle).
  - LOW: pc increments each cycle. On rise, latch period_o=pc, set valid_o=1 and go to DONE.
  - DONE: outputs held; busy_o=0.
- Saturation:
  - If hc or pc reaches 2^CNT_W-1, the counter holds that value, ovf_o=1, and the FSM goes to DONE with valid_o=1.
  - The outputs then carry the saturated values.
- Abort:
  - abort_i in any state other than IDLE returns the FSM to IDLE with valid_o=0.
  - abort_i and arm_i in the same cycle: abort wins.
  - arm_i while busy_o=1 is ignored.
- Edge counter:
  - Independent of the FSM. It increments on rise while cnt_en_i=1 and saturates at all-ones without wrapping.
  - cnt_clr_i takes priority over an increment in the same cycle.
- No input (pulse_i constant):
  - The FSM stays in WAIT_RISE indefinitely and busy_o stays 1.
  - Software uses abort_i to leave.
- Latency: a pulse_i edge reaches rise SYNC_STAGES+1 cycles later. valid_o rises 1 cycle after the closing rise.

Optional Feature:
- Macro: PULSE_MEAS_GLITCH_FILTER_EN
- Defined:
  - A filter stage sits between ps and the edge detector.
  - The filtered level changes only after ps has differed from it for FILT_LEN consecutive cycles.
  - Latency increases by FILT_LEN cycles. High pulses shorter than FILT_LEN cycles are not seen.
- Not defined:
  - No filter logic and FILT_LEN is unused.
  - Every synchronized transition is measured.

Decomposition:
- Package pulse_meas_pkg holds:
  - the FSM state enum (3 bits)
  - the LA bit-index constants: arm, abort, cnt_en, cnt_clr, and the readback field offsets
  - the CNT_W default
- One sub-module, pulse_meas_sync: the synchronizer, the optional glitch filter and the rise detector.
- Counters and the FSM stay in pulse_meas.

Test Plan:
- Arm, then drive 5 cycles high / 7 low, synchronous to the clock -> high_w_o=5, period_o=12, valid_o=1, ovf_o=0.
- Arm, then pulse_i stays 0 for 100 cycles, then abort -> busy_o=1 throughout, then 0 one cycle after the abort; valid_o=0.
- CNT_W=4, arm, high for 20 cycles -> high_w_o=15, ovf_o=1, valid_o=1, FSM in DONE.
- cnt_en_i=1 over 10 pulses, with cnt_clr_i pulsed together with the 6th rise -> edge_cnt_o=4 at the end.
- arm_i and abort_i asserted in the same cycle while in WAIT_RISE -> FSM in IDLE, valid_o=0; then arm alone -> WAIT_RISE.
- With PULSE_MEAS_GLITCH_FILTER_EN and FILT_LEN=4: a 2-cycle glitch, then 10 high / 10 low -> high_w_o=10, period_o=20, and the glitch produces no edge.
